// File: rtl/sonic_pkg.sv
// Shared state encoding, default 100 MHz timing constants and width helper
// for the sonic ranging array controller.
package sonic_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PICK   = 3'd1,
      S_TRIG   = 3'd2,
      S_HOLD   = 3'd3,
      S_MEAS   = 3'd4,
      S_REPORT = 3'd5,
      S_GUARD  = 3'd6
   } state_t;

   localparam int DEF_TRIG_CYC    = 32'd500;
   localparam int DEF_HOLDOFF_CYC = 32'd75000;
   localparam int DEF_TIMEOUT_CYC = 32'd1850000;
   localparam int DEF_GUARD_CYC   = 32'd20000;

   // Channel index width, never below one bit
   function automatic int ch_width(input int ch);
      return (ch > 32'sd1) ? $clog2(ch) : 32'sd1;
   endfunction

endpackage

// File: rtl/sonic_array_ctrl_if.sv
// Request/result bus between the ranging array and its register wrapper.
interface sonic_array_ctrl_if #(
   parameter int CH    = 4,
   parameter int CNT_W = 32
) ();
   import sonic_pkg::*;

   localparam int CH_W = ch_width(CH);

   logic              req;
   logic              abort;
   logic [CH-1:0]     ch_mask;
   logic              busy;
   logic              out_valid;
   logic [CNT_W-1:0]  out_data;
   logic [CH_W-1:0]   out_ch;
   logic              timeout;
   logic              done;

   modport master (
      output req, abort, ch_mask,
      input  busy, out_valid, out_data, out_ch, timeout, done
   );

   modport slave (
      input  req, abort, ch_mask,
      output busy, out_valid, out_data, out_ch, timeout, done
   );

endinterface

// File: rtl/sonic_ch_pick.sv
// Lowest-set-bit finder: index of the next channel to service plus a valid flag.
module sonic_ch_pick #(
   parameter int CH   = 4,
   parameter int CH_W = 2
) (
   input  logic [CH-1:0]   i_mask,
   output logic [CH_W-1:0] o_idx,
   output logic            o_valid
);

   // Scan from the top so the lowest set bit makes the final assignment
   always_comb begin
      o_idx   = '0;
      o_valid = |i_mask;
      for (int i = CH - 1; i >= 0; i--) begin
         o_idx = i_mask[i] ? CH_W'(i) : o_idx;
      end
   end

endmodule

// File: rtl/sonic_array_ctrl.sv
// Multi-channel single-pin ultrasonic ranging controller (trigger, hold-off, echo timing).
// Define SONIC_SYNC_EN to pass echo lines through a 2-flop synchroniser (+2 on counts).
module sonic_array_ctrl
   import sonic_pkg::*;
#(
   parameter int CH          = 4,
   parameter int CNT_W       = 32,
   parameter int TRIG_CYC    = DEF_TRIG_CYC,
   parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int GUARD_CYC   = DEF_GUARD_CYC
) (
   input  logic              clk,
   input  logic              rst,
   sonic_array_ctrl_if.slave bus,
   inout  wire  [CH-1:0]     sig
);

   localparam int CH_W = ch_width(CH);
   localparam logic [CNT_W-1:0] L_TRIG_LAST  = CNT_W'(TRIG_CYC - 1);
   localparam logic [CNT_W-1:0] L_HOLD_LAST  = CNT_W'(HOLDOFF_CYC - 1);
   localparam logic [CNT_W-1:0] L_GUARD_LAST = CNT_W'(GUARD_CYC - 1);
   localparam logic [CNT_W-1:0] L_TIMEOUT    = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] L_ONE        = CNT_W'(1'b1);

   state_t            r_state, w_state_nx;
   logic [CH-1:0]     r_mask, w_mask_nx;
   logic [CH_W-1:0]   r_active, w_active_nx;
   logic [CH_W-1:0]   w_pick_idx;
   logic              w_pick_valid;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
   logic              r_busy, w_busy_nx;
   logic              r_valid, w_valid_nx;
   logic              r_done, w_done_nx;
   logic              w_res_load, w_res_to;
   logic [CNT_W-1:0]  r_data;
   logic [CH_W-1:0]   r_ch;
   logic              r_timeout;
   logic              w_echo;
   logic [CH-1:0]     w_drv;

   sonic_ch_pick #(.CH(CH), .CH_W(CH_W)) u_pick (
      .i_mask  (r_mask),
      .o_idx   (w_pick_idx),
      .o_valid (w_pick_valid)
   );

`ifdef SONIC_SYNC_EN
   logic [CH-1:0] r_sync1, r_sync2;

   // Two-stage synchroniser on the raw sensor lines
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= sig;
         r_sync2 <= r_sync1;
      end
   end

   assign w_echo = r_sync2[r_active];
`else
   assign w_echo = sig[r_active];
`endif

   // Pin drive is gated by rst so the line releases without waiting for a clock
   for (genvar g = 0; g < CH; g++) begin : g_pin
      assign w_drv[g] = (r_state == S_TRIG) && (r_active == CH_W'(g)) && !rst;
      assign sig[g]   = w_drv[g] ? 1'b1 : 1'bz;
   end

   // Next-state, timer and result-capture decisions
   always_comb begin
      w_state_nx  = r_state;
      w_mask_nx   = r_mask;
      w_active_nx = r_active;
      w_cnt_nx    = r_cnt;
      w_busy_nx   = r_busy;
      w_valid_nx  = 1'b0;
      w_done_nx   = 1'b0;
      w_res_load  = 1'b0;
      w_res_to    = 1'b0;
      if (bus.abort && (r_state != S_IDLE)) begin
         w_state_nx = S_IDLE;
         w_busy_nx  = 1'b0;
         w_cnt_nx   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req && (|bus.ch_mask)) begin
                  w_mask_nx  = bus.ch_mask;
                  w_busy_nx  = 1'b1;
                  w_state_nx = S_PICK;
               end else begin
                  w_busy_nx  = 1'b0;
               end
            end
            S_PICK: begin
               if (w_pick_valid) begin
                  w_active_nx = w_pick_idx;
                  w_mask_nx   = r_mask & (r_mask - CH'(1'b1));
                  w_cnt_nx    = '0;
                  w_state_nx  = S_TRIG;
               end else begin
                  w_busy_nx   = 1'b0;
                  w_state_nx  = S_IDLE;
               end
            end
            S_TRIG: begin
               if (r_cnt == L_TRIG_LAST) begin
                  w_cnt_nx   = '0;
                  w_state_nx = S_HOLD;
               end else begin
                  w_cnt_nx   = r_cnt + L_ONE;
               end
            end
            S_HOLD: begin
               if (r_cnt == L_HOLD_LAST) begin
                  w_cnt_nx   = '0;
                  w_state_nx = S_MEAS;
               end else begin
                  w_cnt_nx   = r_cnt + L_ONE;
               end
            end
            S_MEAS: begin
               // Saturation check first: a simultaneous echo fall still reports timeout
               if (r_cnt >= L_TIMEOUT) begin
                  w_res_load = 1'b1;
                  w_res_to   = 1'b1;
                  w_valid_nx = 1'b1;
                  w_state_nx = S_REPORT;
               end else if (!w_echo) begin
                  w_res_load = 1'b1;
                  w_valid_nx = 1'b1;
                  w_state_nx = S_REPORT;
               end else begin
                  w_cnt_nx   = r_cnt + L_ONE;
               end
            end
            S_REPORT: begin
               w_cnt_nx   = '0;
               w_state_nx = S_GUARD;
            end
            S_GUARD: begin
               if (r_cnt == L_GUARD_LAST) begin
                  w_cnt_nx = '0;
                  if (|r_mask) begin
                     w_state_nx = S_PICK;
                  end else begin
                     w_state_nx = S_IDLE;
                     w_busy_nx  = 1'b0;
                     w_done_nx  = 1'b1;
                  end
               end else begin
                  w_cnt_nx = r_cnt + L_ONE;
               end
            end
            default: begin
               w_state_nx = S_IDLE;
               w_busy_nx  = 1'b0;
               w_cnt_nx   = '0;
            end
         endcase
      end
   end

   // State, timer and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_mask    <= '0;
         r_active  <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_valid   <= 1'b0;
         r_done    <= 1'b0;
         r_data    <= '0;
         r_ch      <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_mask   <= w_mask_nx;
         r_active <= w_active_nx;
         r_cnt    <= w_cnt_nx;
         r_busy   <= w_busy_nx;
         r_valid  <= w_valid_nx;
         r_done   <= w_done_nx;
         if (w_res_load) begin
            r_data    <= r_cnt;
            r_ch      <= r_active;
            r_timeout <= w_res_to;
         end
      end
   end

   assign bus.busy      = r_busy;
   assign bus.out_valid = r_valid;
   assign bus.out_data  = r_data;
   assign bus.out_ch    = r_ch;
   assign bus.timeout   = r_timeout;
   assign bus.done      = r_done;

endmodule

// File: tb/tb_sonic_array_ctrl.sv
// Scoreboard bench for sonic_array_ctrl: a sensor model answers each trigger with an echo
// of a chosen length, expectations are queued at request time and a monitor pops them.
module tb_sonic_array_ctrl;

   localparam int CH    = 4;
   localparam int CNT_W = 32;
   localparam int TRIG  = 5;
   localparam int HOLD  = 10;
   localparam int TO    = 100;
   localparam int GUARD = 4;

   typedef struct packed {
      logic is_done;
      int   ch;
      int   data;
      logic to;
   } exp_t;

   logic clk;
   logic rst;
   wire  [CH-1:0] sig;
   logic [CH-1:0] drv_en;
   logic [CH-1:0] drv_val;
   logic [CH-1:0] scan_mask;
   bit   disrupt;
   int   echo_len [CH];
   int   checks;
   int   failures;
   int   stray;
   exp_t exp_q [$];

   sonic_array_ctrl_if #(.CH(CH), .CNT_W(CNT_W)) bus ();

   for (genvar g = 0; g < CH; g++) begin : g_sensor_pin
      assign sig[g] = drv_en[g] ? drv_val[g] : 1'bz;
   end

   sonic_array_ctrl #(
      .CH(CH), .CNT_W(CNT_W), .TRIG_CYC(TRIG), .HOLDOFF_CYC(HOLD),
      .TIMEOUT_CYC(TO), .GUARD_CYC(GUARD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .sig (sig)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input bit ok, input string name, input longint act, input longint want);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, want, $time);
      end
   endtask

   // Monitor: every result strobe or done pulse must match the head of the queue
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (bus.out_valid || bus.done)) begin
         if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_event", {bus.out_valid, bus.done}, 0);
         end else begin
            e = exp_q.pop_front();
            if (bus.out_valid) begin
               check(!e.is_done && !bus.done, "event_kind_result", e.is_done, 0);
               check(int'(bus.out_ch) == e.ch, "out_ch", bus.out_ch, e.ch);
               check(bus.out_data == CNT_W'(e.data), "out_data", bus.out_data, e.data);
               check(bus.timeout == e.to, "timeout", bus.timeout, e.to);
            end else begin
               check(e.is_done, "event_kind_done", e.is_done, 1);
            end
         end
      end
   end

   // Any line high that the sensor is not driving must be a single line of the current scan
   always @(negedge clk) begin
      if (!rst && ((((sig & ~drv_en) & ~scan_mask) != '0) || ($countones(sig & ~drv_en) > 1)))
         stray++;
   end

   // Sensor model: measure the trigger, then hold the echo high for echo_len cycles of MEAS
   initial begin : sensor_model
      logic [CH-1:0] hi;
      int ch, tw, n;
      drv_en  = '0;
      drv_val = '0;
      forever begin
         @(negedge clk);
         hi = sig & ~drv_en;
         if (!rst && hi != '0) begin
            ch = 0;
            for (int i = CH - 1; i >= 0; i--) if (hi[i]) ch = i;
            check($countones(hi) == 1, "single_trigger", $countones(hi), 1);
            tw = 0;
            while (sig[ch] === 1'b1 && tw < 4 * TRIG) begin
               tw++;
               @(negedge clk);
            end
            if (!disrupt) begin
               check(tw == TRIG, "trig_width", tw, TRIG);
               n = echo_len[ch];
               drv_val[ch] = 1'b1;
               drv_en[ch]  = 1'b1;
               for (int j = 0; j < HOLD + n && !disrupt; j++) @(negedge clk);
               drv_val[ch] = 1'b0;
               @(negedge clk);
               drv_en[ch]  = 1'b0;
            end
         end
      end
   end

   task automatic issue(input logic [CH-1:0] mask, input bit track);
      exp_t e;
      scan_mask   = mask;
      bus.ch_mask = mask;
      bus.req     = 1'b1;
      if (track) begin
         for (int i = 0; i < CH; i++) begin
            if (mask[i]) begin
               e.is_done = 1'b0;
               e.ch      = i;
               e.data    = (echo_len[i] >= TO) ? TO : echo_len[i];
               e.to      = (echo_len[i] >= TO);
               exp_q.push_back(e);
            end
         end
         if (mask != '0) begin
            e = '0;
            e.is_done = 1'b1;
            exp_q.push_back(e);
         end
      end
      @(negedge clk);
      bus.req     = 1'b0;
      bus.ch_mask = CH'($urandom);
      check(bus.busy == (mask != '0), "busy_after_req", bus.busy, (mask != '0));
   endtask

   task automatic wait_idle(input int bound, input bit poke);
      int n;
      n = 0;
      while (n < bound) begin
         @(negedge clk);
         n++;
         if (!bus.busy) break;
         bus.req     = poke && ($urandom_range(0, 7) == 0);
         bus.ch_mask = CH'($urandom);
      end
      bus.req = 1'b0;
      check(!bus.busy, "scan_finishes", n, bound);
      repeat (2) @(negedge clk);
   endtask

   initial begin : main
      int n;
      logic [CH-1:0] m;
      checks = 0; failures = 0; stray = 0;
      rst = 1'b1; disrupt = 1'b0; scan_mask = '0;
      bus.req = 1'b0; bus.abort = 1'b0; bus.ch_mask = '0;
      for (int i = 0; i < CH; i++) echo_len[i] = 0;

      repeat (3) @(negedge clk);
      check({bus.busy, bus.out_valid, bus.timeout, bus.done} == 4'b0000, "reset_flags",
            {bus.busy, bus.out_valid, bus.timeout, bus.done}, 0);
      check(bus.out_data == '0 && bus.out_ch == '0, "reset_data", bus.out_data, 0);
      check((sig & ~drv_en) == '0, "reset_sig_released", sig, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      echo_len[0] = 37;
      issue(4'b0001, 1'b1);
      wait_idle(1000, 1'b0);

      echo_len[1] = 20; echo_len[3] = 60;
      issue(4'b1010, 1'b1);
      wait_idle(1000, 1'b0);
      check(stray == 0, "other_lines_released", stray, 0);

      echo_len[2] = TO + 1;
      issue(4'b0100, 1'b1);
      wait_idle(1000, 1'b0);

      issue(4'b0000, 1'b1);
      repeat (20) @(negedge clk);
      check(!bus.busy, "zero_mask_idle", bus.busy, 0);

      // Abort in MEAS of channel 0 of a two-channel scan
      echo_len[0] = 80; echo_len[2] = 30;
      issue(4'b0101, 1'b0);
      n = 0;
      while (!drv_en[0] && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(drv_en[0], "abort_echo_started", drv_en[0], 1);
      repeat (HOLD + 10) @(negedge clk);
      bus.abort = 1'b1;
      disrupt   = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check(!bus.busy, "abort_busy_low", bus.busy, 0);
      check((sig & ~drv_en) == '0, "abort_sig_released", sig, 0);
      repeat (20) @(negedge clk);
      check(!bus.busy && exp_q.size() == 0, "abort_stays_idle", bus.busy, 0);
      check(bus.out_data == CNT_W'(TO) && bus.out_ch == 2'd2 && bus.timeout,
            "abort_holds_result", bus.out_data, TO);
      disrupt = 1'b0;
      repeat (3) @(negedge clk);

      echo_len[0] = 25;
      issue(4'b0001, 1'b1);
      wait_idle(1000, 1'b0);

      // Reset asserted between clock edges during a trigger pulse
      disrupt = 1'b1;
      issue(4'b0001, 1'b0);
      @(negedge clk);
      check(sig[0] === 1'b1, "trig_before_rst", sig[0], 1);
      #2 rst = 1'b1;
      #1;
      check(sig[0] !== 1'b1, "rst_sig_released", sig[0], 0);
      check({bus.busy, bus.out_valid, bus.timeout, bus.done} == 4'b0000, "rst_flags",
            {bus.busy, bus.out_valid, bus.timeout, bus.done}, 0);
      check(bus.out_data == '0 && bus.out_ch == '0, "rst_data", bus.out_data, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      disrupt = 1'b0;

      // Randomised scans with stray req/ch_mask activity while busy
      for (int k = 0; k < 10; k++) begin
         m = CH'($urandom_range(1, (1 << CH) - 1));
         for (int i = 0; i < CH; i++) echo_len[i] = $urandom_range(0, TO + 1);
         issue(m, 1'b1);
         wait_idle(1000, 1'b1);
      end

      repeat (5) @(negedge clk);
      check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
      check(stray == 0, "stray_drive", stray, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
